// File: rtl/req_pkg.sv
// ============================================================================
// req_pkg : request command type and widths shared by the request switch
// Revision: 1.0
// ============================================================================
`default_nettype none

package req_pkg;

  localparam int REQ_ADDR_W = 16;
  localparam int REQ_LEN_W  = 4;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_RD   = 2'd1,
    CMD_WR   = 2'd2
  } cmd_e;

  typedef struct packed {
    cmd_e                  cmd;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_LEN_W-1:0]  len;
    logic                  lock;
  } reqcmd_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/req_fifo.sv
// ============================================================================
// req_fifo : per-channel request buffer, DEPTH entries, first-word head view
// Revision: 1.0
// ============================================================================
`default_nettype none

module req_fifo
  import req_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  reqcmd_t din,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output reqcmd_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  reqcmd_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage carries no reset; only the occupancy bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/req_sw_arb.sv
// ============================================================================
// req_sw_arb : NUM_CH-way request switch, round-robin with locked sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module req_sw_arb
  import req_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 2,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  reqcmd_t           AReq [NUM_CH],
  input  logic [NUM_CH-1:0] a_valid,
  output logic [NUM_CH-1:0] a_ready,
  output reqcmd_t           BReq,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [CH_W-1:0]   b_ch
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop;
  reqcmd_t           head [NUM_CH];

  arb_state_e        state;
  logic [CH_W-1:0]   lock_ch;
  logic [CH_W-1:0]   rr_ptr;

  logic              load;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_ch;
  logic [CH_W-1:0]   cand;
  logic [CH_W-1:0]   next_rr;

  assign a_ready = ~full;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
    req_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (a_valid[i] && !full[i]),
      .din   (AReq[i]),
      .pop   (pop[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  // Output register accepts a new request when empty or being drained.
  assign load    = !b_valid || b_ready;
  assign next_rr = CH_W'((int'(gnt_ch) + 1) % NUM_CH);

  // Walk from the farthest offset back so the nearest non-empty channel wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    cand    = '0;
    if (state == LOCKED) begin
      gnt_vld = !empty[lock_ch];
      gnt_ch  = lock_ch;
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
        if (!empty[cand]) begin
          gnt_vld = 1'b1;
          gnt_ch  = cand;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && gnt_vld) pop[gnt_ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_ch <= '0;
      rr_ptr  <= '0;
      b_valid <= 1'b0;
      BReq    <= '0;
      b_ch    <= '0;
    end else if (load) begin
      b_valid <= gnt_vld;
      if (gnt_vld) begin
        BReq <= head[gnt_ch];
        b_ch <= gnt_ch;
        if (head[gnt_ch].lock) begin
          state   <= LOCKED;
          lock_ch <= gnt_ch;
        end else begin
          state  <= IDLE;
          rr_ptr <= next_rr;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_req_sw_arb.sv
// ============================================================================
// tb_req_sw_arb : directed self-checking bench for req_sw_arb (4 ch, depth 2)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_req_sw_arb;
  import req_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  reqcmd_t    areq [4];
  logic [3:0] a_valid;
  logic [3:0] a_ready;
  reqcmd_t    breq;
  logic       b_valid;
  logic       b_ready;
  logic [1:0] b_ch;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  req_sw_arb #(
    .NUM_CH (4),
    .DEPTH  (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .AReq    (areq),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .BReq    (breq),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_ch    (b_ch)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic reqcmd_t mk(input cmd_e c, input logic [15:0] a, input logic l);
    reqcmd_t r;
    r.cmd  = c;
    r.addr = a;
    r.len  = 4'h1;
    r.lock = l;
    return r;
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    a_valid = '0;
    b_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] ch, input logic [15:0] addr);
    check({tag, "_valid"}, 32'(b_valid), 32'd1);
    check({tag, "_ch"},    32'(b_ch),    32'(ch));
    check({tag, "_addr"},  32'(breq.addr), 32'(addr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic       will_push;
    int         sent;
    int         rcv;

    for (int i = 0; i < 4; i++) areq[i] = mk(CMD_RD, 16'h0, 1'b0);

    // Reset held 3 cycles with all channels requesting
    rst_n   = 1'b0;
    a_valid = 4'b1111;
    b_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_bvalid", 32'(b_valid), 32'd0);
      check("rst_aready", 32'(a_ready), 32'hf);
      check("rst_breq",   32'(breq),    32'd0);
    end
    rst_n   = 1'b1;
    a_valid = 4'b0001;
    areq[0] = mk(CMD_RD, 16'h0011, 1'b0);
    @(negedge clk);
    check("lat_t1_bvalid", 32'(b_valid), 32'd0);
    a_valid = '0;
    @(negedge clk);
    expect_out("lat_t2", 2'd0, 16'h0011);
    b_ready = 1'b1;
    @(negedge clk);
    check("lat_drain_bvalid", 32'(b_valid), 32'd0);

    // Round robin with all channels continuously valid
    do_reset();
    for (int i = 0; i < 4; i++) areq[i] = mk(CMD_RD, 16'(i * 16), 1'b0);
    a_valid = 4'b1111;
    b_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_bvalid", 32'(b_valid), 32'd1);
      check("rr_bch",    32'(b_ch),    32'(k % 4));
    end
    a_valid = '0;

    // Backpressure on channel 2
    do_reset();
    b_ready = 1'b0;
    sent    = 0;
    for (int i = 0; i < 10; i++) begin
      areq[2]   = mk(CMD_WR, 16'(sent), 1'b0);
      a_valid   = 4'b0100;
      will_push = a_ready[2];
      @(negedge clk);
      if (will_push) sent++;
      if (i >= 1) expect_out("bp_hold", 2'd2, 16'd0);
    end
    check("bp_absorbed", 32'(sent),    32'd3);
    check("bp_aready",   32'(a_ready), 32'hb);
    a_valid = '0;
    b_ready = 1'b1;
    @(negedge clk);
    expect_out("bp_drain1", 2'd2, 16'd1);
    @(negedge clk);
    expect_out("bp_drain2", 2'd2, 16'd2);
    @(negedge clk);
    check("bp_empty", 32'(b_valid), 32'd0);

    // Lock sequence on channel 1, starting with rr_ptr = 1
    do_reset();
    areq[0] = mk(CMD_RD, 16'h0001, 1'b0);
    a_valid = 4'b0001;
    @(negedge clk);
    a_valid = '0;
    @(negedge clk);
    @(negedge clk);
    b_ready = 1'b0;
    areq[0] = mk(CMD_RD,   16'h0010, 1'b0);
    areq[1] = mk(CMD_WR,   16'h0021, 1'b1);
    areq[3] = mk(CMD_IDLE, 16'h0030, 1'b0);
    a_valid = 4'b1011;
    @(negedge clk);
    areq[1] = mk(CMD_WR, 16'h0022, 1'b1);
    a_valid = 4'b0010;
    @(negedge clk);
    expect_out("lk_first", 2'd1, 16'h0021);
    areq[1] = mk(CMD_WR, 16'h0023, 1'b0);
    @(negedge clk);
    expect_out("lk_hold", 2'd1, 16'h0021);
    a_valid = '0;
    b_ready = 1'b1;
    @(negedge clk);
    expect_out("lk_second", 2'd1, 16'h0022);
    @(negedge clk);
    expect_out("lk_third", 2'd1, 16'h0023);
    @(negedge clk);
    expect_out("lk_after3", 2'd3, 16'h0030);
    check("lk_idle_cmd", 32'(breq.cmd), 32'(CMD_IDLE));
    @(negedge clk);
    expect_out("lk_after0", 2'd0, 16'h0010);
    @(negedge clk);
    check("lk_empty", 32'(b_valid), 32'd0);

    // Stream 20 requests through channel 0 with toggling b_ready
    do_reset();
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 300 && rcv < 20; cyc++) begin
      b_ready    = ((cyc % 3) != 0);
      areq[0]    = mk(CMD_WR, 16'(sent), 1'b0);
      a_valid[0] = (sent < 20);
      will_push  = a_valid[0] && a_ready[0];
      if (b_valid && b_ready) begin
        check("wrap_addr", 32'(breq.addr), 32'(rcv));
        check("wrap_ch",   32'(b_ch),      32'd0);
        rcv++;
      end
      @(negedge clk);
      if (will_push) sent++;
    end
    a_valid = '0;
    check("wrap_count", 32'(rcv), 32'd20);

    // Reset while locked on channel 2
    do_reset();
    areq[1] = mk(CMD_RD, 16'h0041, 1'b0);
    a_valid = 4'b0010;
    @(negedge clk);
    a_valid = '0;
    @(negedge clk);
    expect_out("rl_pre", 2'd1, 16'h0041);
    @(negedge clk);
    areq[2] = mk(CMD_WR, 16'h0042, 1'b1);
    a_valid = 4'b0100;
    @(negedge clk);
    areq[0] = mk(CMD_RD, 16'h0050, 1'b0);
    areq[3] = mk(CMD_RD, 16'h0053, 1'b0);
    a_valid = 4'b1001;
    @(negedge clk);
    expect_out("rl_lock", 2'd2, 16'h0042);
    a_valid = '0;
    @(negedge clk);
    check("rl_stall", 32'(b_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rl_rst_bvalid", 32'(b_valid), 32'd0);
    check("rl_rst_aready", 32'(a_ready), 32'hf);
    areq[0] = mk(CMD_RD, 16'h0060, 1'b0);
    areq[1] = mk(CMD_RD, 16'h0061, 1'b0);
    areq[3] = mk(CMD_RD, 16'h0063, 1'b0);
    a_valid = 4'b1011;
    @(negedge clk);
    a_valid = '0;
    @(negedge clk);
    expect_out("rl_first", 2'd0, 16'h0060);
    @(negedge clk);
    expect_out("rl_second", 2'd1, 16'h0061);
    @(negedge clk);
    expect_out("rl_third", 2'd3, 16'h0063);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
